// File: rtl/bidiag_pkg.sv
// bidiag_pkg: shared widths, FSM encoding and band output ordering constants.
package bidiag_pkg;
   localparam int BIT_NUM = 18;
   localparam int MAT_DIM = 4;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [3:0] LAST_IDX = 4'd15;
   // output words run d0,e0,d1,e1,d2,e2,d3: even slots diagonal, odd slots superdiagonal
   localparam logic [2:0] LAST_OUT = 3'd6;
endpackage

// File: rtl/abs_tol_cmp.sv
// abs_tol_cmp: flags a signed word whose magnitude exceeds an unsigned threshold.
module abs_tol_cmp #(
   parameter int W = 18,
   parameter logic [W-1:0] TOL = '0
) (
   input  logic signed [W-1:0] x,
   output logic                gt
);
   logic [W-1:0] mag;
   always_comb begin
      // unsigned view makes the most negative input come out as 2^(W-1)
      mag = x[W-1] ? -x : x;
      gt = mag > TOL;
   end
endmodule

// File: rtl/bidiag_band_extract.sv
// bidiag_band_extract: collects a 4x4 complex matrix burst, checks the off-band
// entries are nulled and streams the real bidiagonal band out with handshake.
module bidiag_band_extract #(
   parameter int BIT_NUM = bidiag_pkg::BIT_NUM,
   parameter int MAT_DIM = bidiag_pkg::MAT_DIM,
   parameter logic [BIT_NUM-1:0] TOL = 18'd64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   input  logic signed [BIT_NUM-1:0] R_i,
   input  logic signed [BIT_NUM-1:0] I_i,
   input  logic                      ready_i,
   output logic signed [BIT_NUM-1:0] D_o,
   output logic                      valid_o,
   output logic                      last_o,
   output logic                      err_o,
   output logic                      short_o,
   output logic                      overrun_o
);
   import bidiag_pkg::*;
   logic [1:0] state;
   logic [3:0] idx;
   logic [2:0] cnt;
   logic err;
   logic signed [BIT_NUM-1:0] d [MAT_DIM];
   logic signed [BIT_NUM-1:0] e [MAT_DIM-1];
   logic re_bad, im_bad;
   logic [3:0] cur;
   logic [1:0] row, col;
   logic diag, sup, fail;
   logic [2:0] nxt;
   abs_tol_cmp #(.W(BIT_NUM), .TOL(TOL)) u_re (.x(R_i), .gt(re_bad));
   abs_tol_cmp #(.W(BIT_NUM), .TOL(TOL)) u_im (.x(I_i), .gt(im_bad));
   always_comb begin
      cur = (state == S_IDLE) ? 4'd0 : idx;
      row = cur[3:2];
      col = cur[1:0];
      diag = row == col;
      sup = {1'b0, col} == {1'b0, row} + 3'd1;
      fail = im_bad | (~(diag | sup) & re_bad);
      nxt = cnt + 3'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx <= '0;
         cnt <= '0;
         err <= 1'b0;
         D_o <= '0;
         valid_o <= 1'b0;
         last_o <= 1'b0;
         err_o <= 1'b0;
         short_o <= 1'b0;
         overrun_o <= 1'b0;
         for (int i = 0; i < MAT_DIM; i++) d[i] <= '0;
         for (int i = 0; i < MAT_DIM - 1; i++) e[i] <= '0;
      end else begin
         short_o <= 1'b0;
         overrun_o <= 1'b0;
         if (state != S_SEND && valid_i) begin
            if (diag) d[row] <= R_i;
            if (sup) e[row] <= R_i;
         end
         case (state)
            S_IDLE: if (valid_i) begin
               state <= S_COLLECT;
               idx <= 4'd1;
               err <= fail;
            end
            S_COLLECT: if (!valid_i) begin
               short_o <= 1'b1;
               state <= S_IDLE;
            end else begin
               err <= err | fail;
               idx <= idx + 4'd1;
               if (idx == LAST_IDX) begin
                  state <= S_SEND;
                  cnt <= '0;
                  valid_o <= 1'b1;
                  D_o <= d[0];
               end
            end
            S_SEND: begin
               overrun_o <= valid_i;
               if (ready_i) begin
                  if (cnt == LAST_OUT) begin
                     state <= S_IDLE;
                     valid_o <= 1'b0;
                     last_o <= 1'b0;
                     err_o <= 1'b0;
                  end else begin
                     cnt <= nxt;
                     D_o <= nxt[0] ? e[nxt[2:1]] : d[nxt[2:1]];
                     last_o <= nxt == LAST_OUT;
                     err_o <= (nxt == LAST_OUT) & err;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bidiag_band_extract.sv
// tb_bidiag_band_extract: randomized and directed bursts checked against a
// matrix-level model of band extraction and off-band tolerance checking.
module tb_bidiag_band_extract;
   localparam int TOLV = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid_i = 1'b0;
   logic ready_i = 1'b0;
   logic signed [17:0] R_i = '0;
   logic signed [17:0] I_i = '0;
   logic signed [17:0] D_o;
   logic valid_o, last_o, err_o, short_o, overrun_o;
   int checks = 0;
   int failures = 0;
   int mr [16];
   int mi [16];

   bidiag_band_extract dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .R_i(R_i), .I_i(I_i),
      .ready_i(ready_i), .D_o(D_o), .valid_o(valid_o), .last_o(last_o),
      .err_o(err_o), .short_o(short_o), .overrun_o(overrun_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int absv(input int v);
      return v < 0 ? -v : v;
   endfunction

   function automatic int want_word(input int k);
      int r = k / 2;
      return (k % 2 == 0) ? mr[r * 4 + r] : mr[r * 4 + r + 1];
   endfunction

   function automatic bit want_err();
      for (int i = 0; i < 16; i++) begin
         int r = i / 4;
         int c = i % 4;
         bit band = (r == c) || (c == r + 1);
         if (absv(mi[i]) > TOLV || (!band && absv(mr[i]) > TOLV)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic ref_matrix();
      for (int i = 0; i < 16; i++) begin
         mr[i] = 0;
         mi[i] = 0;
      end
      for (int r = 0; r < 4; r++) mr[r * 5] = 100 * (r + 1);
      for (int r = 0; r < 3; r++) mr[r * 5 + 1] = 10 * (r + 1);
   endtask

   task automatic rand_matrix();
      bit bad = 1'($urandom_range(0, 1));
      int pos = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
         int r = i / 4;
         int c = i % 4;
         bit band = (r == c) || (c == r + 1);
         mr[i] = band ? int'($urandom_range(0, 262143)) - 131072 : int'($urandom_range(0, 2 * TOLV)) - TOLV;
         mi[i] = int'($urandom_range(0, 2 * TOLV)) - TOLV;
      end
      if (bad) begin
         int big = int'($urandom_range(TOLV + 1, 131072));
         if ($urandom_range(0, 1) == 0) big = -big;
         if ($urandom_range(0, 1) == 0) mi[pos] = big;
         else mr[pos] = big;
      end
   endtask

   task automatic drive_words(input int n);
      for (int i = 0; i < n; i++) begin
         valid_i = 1'b1;
         R_i = 18'(mr[i]);
         I_i = 18'(mi[i]);
         step();
      end
      valid_i = 1'b0;
      R_i = '0;
      I_i = '0;
   endtask

   // mode 0: ready always, 1: ready toggles starting high, 2: random ready
   task automatic run_burst(input string tag, input int mode, input int ovr,
                            input int rst_at, input int want_cycles);
      int k = 0;
      int cyc = 0;
      int ovr_seen = 0;
      bit done = 1'b0;
      bit aborted = 1'b0;
      bit rd;
      bit werr = want_err();
      drive_words(16);
      check({tag, ":latency"}, valid_o, 1);
      while (!done && cyc < 80) begin
         check({tag, ":valid"}, valid_o, 1);
         check({tag, ":data"}, D_o, want_word(k));
         check({tag, ":last"}, last_o, k == 6);
         check({tag, ":err"}, err_o, (k == 6) ? werr : 1'b0);
         rd = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         ready_i = rd;
         valid_i = cyc < ovr;
         step();
         cyc++;
         ovr_seen += int'(overrun_o);
         if (rd) k++;
         if (k == rst_at) begin
            rst = 1'b1;
            ready_i = 1'b0;
            valid_i = 1'b0;
            step();
            rst = 1'b0;
            check({tag, ":rst_D"}, D_o, 0);
            check({tag, ":rst_valid"}, valid_o, 0);
            check({tag, ":rst_last"}, last_o, 0);
            check({tag, ":rst_err"}, err_o, 0);
            check({tag, ":rst_flags"}, {short_o, overrun_o}, 0);
            step();
            check({tag, ":rst_quiet"}, {valid_o, short_o, overrun_o}, 0);
            done = 1'b1;
            aborted = 1'b1;
         end else if (k == 7) begin
            check({tag, ":drop"}, valid_o, 0);
            if (want_cycles > 0) check({tag, ":cycles"}, cyc, want_cycles);
            done = 1'b1;
         end
      end
      ready_i = 1'b0;
      valid_i = 1'b0;
      check({tag, ":done"}, done, 1);
      if (!aborted) check({tag, ":overrun"}, ovr_seen, ovr);
   endtask

   initial begin
      repeat (3) step();
      check("reset_D", D_o, 0);
      check("reset_valid", valid_o, 0);
      check("reset_last", last_o, 0);
      check("reset_err", err_o, 0);
      check("reset_flags", {short_o, overrun_o}, 0);
      rst = 1'b0;
      step();

      ref_matrix();
      run_burst("exact", 0, 0, -1, 7);
      ref_matrix();
      mr[8] = 65;
      check("tol65_model", want_err(), 1);
      run_burst("tol65", 0, 0, -1, 7);
      ref_matrix();
      mr[8] = 64;
      run_burst("tol64", 0, 0, -1, 7);
      ref_matrix();
      mr[8] = -65;
      run_burst("tolneg65", 0, 0, -1, 7);
      ref_matrix();
      run_burst("toggle", 1, 0, -1, 13);

      ref_matrix();
      drive_words(9);
      step();
      check("short_pulse", short_o, 1);
      check("short_novalid", valid_o, 0);
      step();
      check("short_single", short_o, 0);
      check("short_idle", valid_o, 0);
      ref_matrix();
      run_burst("after_short", 0, 0, -1, 7);

      ref_matrix();
      run_burst("overrun", 0, 3, -1, 7);

      ref_matrix();
      run_burst("reset_mid", 0, 0, 5, 0);
      ref_matrix();
      mi[5] = -131072;
      run_burst("min_imag", 0, 0, -1, 7);

      for (int t = 0; t < 12; t++) begin
         rand_matrix();
         run_burst("random", 2, $urandom_range(0, 3), -1, 0);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bidiag_band_extract.md
BIDIAG_BAND_EXTRACT -- requirements
Module: bidiag_band_extract

Interface
REQ-001 Parameter BIT_NUM, default 18, SHALL be the signed sample width of every real/imaginary word.
REQ-002 Parameter MAT_DIM, default 4, SHALL be the matrix dimension; the burst length SHALL be MAT_DIM*MAT_DIM = 16.
REQ-003 Parameter TOL, default 18'd64, SHALL be the unsigned magnitude threshold for "nulled" entries.
REQ-004 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 valid_i  input  1  SHALL mark a valid matrix word from the upstream bidiagonalizer; bursts are contiguous.
REQ-007 R_i, I_i  input  BIT_NUM signed each  SHALL carry the real/imaginary parts, row-major, index {row,col}.
REQ-008 ready_i  input  1  SHALL be downstream acceptance of the current output word.
REQ-009 D_o  output  BIT_NUM signed  SHALL carry the band element being emitted.
REQ-010 valid_o  output  1  SHALL mark D_o valid.
REQ-011 last_o  output  1  SHALL be high with the final (7th) word of a band set.
REQ-012 err_o  output  1  SHALL be high with last_o when any off-band check failed for that matrix.
REQ-013 short_o, overrun_o  output  1 each  SHALL be one-cycle pulses flagging truncated bursts and dropped input words.

Function
REQ-014 States SHALL be IDLE, COLLECT, SEND.
REQ-015 IDLE SHALL go to COLLECT on valid_i, capturing that word as index 0.
REQ-016 COLLECT SHALL capture one word per valid_i cycle, incrementing a 4-bit index.
REQ-017 Word with row==col SHALL be stored as diagonal d[row] (real part only).
REQ-018 Word with col==row+1 SHALL be stored as superdiagonal e[row] (real part only).
REQ-019 Off-band words SHALL fail if |R_i|>TOL or |I_i|>TOL; band words SHALL fail if |I_i|>TOL; failures set a sticky err bit cleared on entry to COLLECT.
REQ-020 Magnitude SHALL be computed as BIT_NUM-bit unsigned; |-2^(BIT_NUM-1)| = 2^(BIT_NUM-1) without overflow.
REQ-021 After index 15 is captured, state SHALL be SEND the next cycle with valid_o high (latency: one cycle after the 16th word).
REQ-022 If valid_i drops in COLLECT before index 15, the partial matrix SHALL be discarded, short_o pulsed, state IDLE.
REQ-023 SEND SHALL emit d0,e0,d1,e1,d2,e2,d3 in that order; a word advances only when valid_o && ready_i.
REQ-024 D_o, last_o, err_o SHALL hold stable while valid_o && !ready_i.
REQ-025 After the 7th handshake, valid_o SHALL drop the next cycle and state SHALL be IDLE.
REQ-026 valid_i high during SEND SHALL be ignored and pulse overrun_o per dropped word.
REQ-027 A new burst SHALL start no earlier than the first cycle in IDLE; back-to-back start in the cycle after the last handshake SHALL be accepted.

Reset
REQ-028 On rst: state IDLE, index 0, d/e registers 0, err 0, D_o 0, valid_o 0, last_o 0, err_o 0, short_o 0, overrun_o 0.
REQ-029 rst asserted mid-COLLECT or mid-SEND SHALL abort with no further output and no flag pulses.

Structure
REQ-030 Shared package bidiag_pkg SHALL hold BIT_NUM, MAT_DIM, the state encoding and output-order constants.
REQ-031 One sub-module abs_tol_cmp SHALL compute |x|>TOL; two instances (real, imaginary).

Verification
REQ-032 Exact bidiagonal burst (d=100,200,300,400; e=10,20,30; rest 0), ready_i=1 -> 7 words 100,10,200,20,300,30,400 on consecutive cycles, last_o on 400, err_o=0.
REQ-033 Same burst, entry {2,0} R=65 -> err_o=1 with last_o; entry {2,0} R=64 -> err_o=0.
REQ-034 ready_i toggled 1/0 each cycle -> same 7 values, each held stable while stalled, 13 cycles total.
REQ-035 valid_i drops after 9 words -> short_o single pulse, no valid_o, next full burst emits correctly.
REQ-036 valid_i asserted 3 cycles during SEND -> 3 overrun_o pulses, output sequence unchanged.
REQ-037 rst after 5th output word -> all outputs 0 next cycle; following burst with I of {1,1} = -131072 -> err_o=1.
